// File: rtl/i2c_reg_slave.sv
// I2C target bridging the bus to a NUM_REGS x 8-bit register port: pointer byte, burst read/write, repeated START.
// Optional SCL/SDA glitch filters are built when I2C_SLAVE_FILTER_EN is defined.
`timescale 1ns/1ps
module i2c_reg_slave #(
  parameter logic [6:0] ADDRESS    = 7'h6A,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 4,
  localparam int        PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  input  logic [7:0]       reg_rdata,
  output logic             reg_re,
  output logic             busy,
  output logic             addressed,
  output logic             ack_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  // Pin synchronisers reset to the idle-bus level so reset release never fakes a START/STOP.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_cur, sda_cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  logic             scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_cnt_d  = '0;
    sda_filt_d = sda_filt_q;
    sda_cnt_d  = '0;
    if (scl_sync_q[1] != scl_filt_q) begin
      if (scl_cnt_q == CNT_W'(FILTER_LEN - 1)) scl_filt_d = scl_sync_q[1];
      else                                     scl_cnt_d  = scl_cnt_q + 1'b1;
    end
    if (sda_sync_q[1] != sda_filt_q) begin
      if (sda_cnt_q == CNT_W'(FILTER_LEN - 1)) sda_filt_d = sda_sync_q[1];
      else                                     sda_cnt_d  = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign scl_cur = scl_filt_q;
  assign sda_cur = sda_filt_q;
`else
  logic filter_len_unused;
  assign filter_len_unused = (FILTER_LEN > 0);
  assign scl_cur = scl_sync_q[1];
  assign sda_cur = sda_sync_q[1];
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_cur;
      sda_prev_q <= sda_cur;
    end
  end

  assign scl_rise  = scl_cur & ~scl_prev_q;
  assign scl_fall  = ~scl_cur & scl_prev_q;
  assign start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             rw_q, rw_d;
  logic             ack_phase_q, ack_phase_d;
  logic             ack_bit_q, ack_bit_d;
  logic             sda_oe_q, sda_oe_d;
  logic [PTR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_we_q, reg_we_d;
  logic             reg_re_q, reg_re_d;
  logic             busy_q, busy_d;
  logic             addressed_q, addressed_d;
  logic             ack_error_q, ack_error_d;

  logic [7:0]       byte_in;
  logic             last_bit, addr_match, ptr_ok;
  logic [PTR_W-1:0] ptr_inc;

  assign byte_in    = {shift_q[6:0], sda_cur};
  assign last_bit   = (bit_cnt_q == 3'd0);
  assign addr_match = (byte_in[7:1] == ADDRESS);
  assign ptr_ok     = ({1'b0, byte_in} < 9'(NUM_REGS));
  assign ptr_inc    = (reg_addr_q == PTR_W'(NUM_REGS - 1)) ? '0 : reg_addr_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ACK slots end on the SCL fall that follows the 9th rise (ack_phase_q set).
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else if (scl_rise && last_bit) begin
      case (state_q)
        S_ADDR:  state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
        S_PTR:   state_d = ptr_ok ? S_PTR_ACK : S_IGNORE;
        S_WDATA: state_d = S_WDATA_ACK;
        S_RDATA: state_d = S_RDATA_ACK;
        default: ;
      endcase
    end else if (scl_fall && ack_phase_q) begin
      case (state_q)
        S_ADDR_ACK:             state_d = rw_q ? S_RDATA : S_PTR;
        S_PTR_ACK, S_WDATA_ACK: state_d = S_WDATA;
        S_RDATA_ACK:            state_d = ack_bit_q ? S_IGNORE : S_RDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    ack_phase_d = ack_phase_q;
    ack_bit_d   = ack_bit_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    ack_error_d = ack_error_q;

    // Write pointer advances as the write strobe drops.
    if (reg_we_q) reg_addr_d = ptr_inc;

    if (stop_det) begin
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else if (start_det) begin
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      ack_error_d = 1'b0;
      bit_cnt_d   = 3'd7;
    end else if (reg_re_q) begin
      shift_d  = reg_rdata;
      sda_oe_d = ~reg_rdata[7];
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (last_bit) begin
            ack_phase_d = 1'b0;
            if (state_q == S_ADDR) begin
              if (addr_match) begin
                addressed_d = 1'b1;
                rw_d        = byte_in[0];
              end
            end else if (state_q == S_PTR) begin
              if (ptr_ok) reg_addr_d  = byte_in[PTR_W-1:0];
              else        ack_error_d = 1'b1;
            end else begin
              reg_wdata_d = byte_in;
              reg_we_d    = 1'b1;
            end
          end
        end
        S_RDATA: begin
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (last_bit) ack_phase_d = 1'b0;
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: ack_phase_d = 1'b1;
        S_RDATA_ACK: begin
          ack_phase_d = 1'b1;
          ack_bit_d   = sda_cur;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (!ack_phase_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            if (state_q == S_ADDR_ACK && rw_q) reg_re_d = 1'b1;
          end
        end
        S_RDATA: begin
          shift_d  = {shift_q[6:0], 1'b0};
          sda_oe_d = ~shift_q[6];
        end
        S_RDATA_ACK: begin
          sda_oe_d = 1'b0;
          if (ack_phase_q) begin
            reg_addr_d = ptr_inc;
            bit_cnt_d  = 3'd7;
            reg_re_d   = ~ack_bit_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= 3'd7;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      ack_bit_q   <= 1'b1;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      ack_bit_q   <= ack_bit_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      ack_error_q <= ack_error_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: an I2C master model drives the bus, a small register bank answers the register port.
`timescale 1ns/1ps
module tb_i2c_reg_slave;
  localparam int NUM_REGS = 16;
  localparam int PTR_W    = 4;
  localparam int Q        = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_in, sda_oe, reg_we, reg_re, busy, addressed, ack_error;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  logic [7:0] mem [NUM_REGS];
  logic [PTR_W-1:0] we_addr_log [64];
  logic [7:0] we_data_log [64];
  int we_cnt = 0, re_cnt = 0, oe_cyc = 0, adr_cyc = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_reg_slave #(.ADDRESS(7'h6A), .NUM_REGS(NUM_REGS), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .reg_re(reg_re), .busy(busy),
    .addressed(addressed), .ack_error(ack_error)
  );

  // Register bank and activity log
  always @(negedge clk) begin
    if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
      we_addr_log[we_cnt[5:0]] <= reg_addr;
      we_data_log[we_cnt[5:0]] <= reg_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (reg_re)    re_cnt  <= re_cnt + 1;
    if (sda_oe)    oe_cyc  <= oe_cyc + 1;
    if (addressed) adr_cyc <= adr_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl = 1'b1; tick(Q);
    s = sda_in; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(nack, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_oe"},    sda_oe,    0);
    check({tag, "_reg_addr"},  reg_addr,  0);
    check({tag, "_reg_wdata"}, reg_wdata, 0);
    check({tag, "_reg_we"},    reg_we,    0);
    check({tag, "_reg_re"},    reg_re,    0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_addressed"}, addressed, 0);
    check({tag, "_ack_error"}, ack_error, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic nack, s;
    logic [7:0] rd;
    int we0, re0, oe0, ad0;

    tick(4);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(4);

    // Burst write: ptr 3, data A5, 5A
    we0 = we_cnt;
    i2c_start();
    check("a_busy", busy, 1);
    write_byte(8'hD4, nack); check("a_ack_addr", nack, 0);
    check("a_addressed", addressed, 1);
    write_byte(8'h03, nack); check("a_ack_ptr", nack, 0);
    write_byte(8'hA5, nack); check("a_ack_d0", nack, 0);
    write_byte(8'h5A, nack); check("a_ack_d1", nack, 0);
    i2c_stop();
    check("a_we_count", we_cnt - we0, 2);
    check("a_we0_addr", we_addr_log[we0[5:0]], 3);
    check("a_we0_data", we_data_log[we0[5:0]], 8'hA5);
    check("a_we1_addr", we_addr_log[we0[5:0] + 6'd1], 4);
    check("a_we1_data", we_data_log[we0[5:0] + 6'd1], 8'h5A);
    check("a_ptr_end", reg_addr, 5);
    check("a_busy_end", busy, 0);

    // Load regs 2..4, then pointer write + repeated START + 3-byte read
    i2c_start();
    write_byte(8'hD4, nack);
    write_byte(8'h02, nack);
    write_byte(8'h11, nack);
    write_byte(8'h22, nack);
    write_byte(8'h33, nack);
    i2c_stop();
    re0 = re_cnt;
    i2c_start();
    write_byte(8'hD4, nack); check("b_ack_addw", nack, 0);
    write_byte(8'h02, nack); check("b_ack_ptr", nack, 0);
    i2c_start();
    write_byte(8'hD5, nack); check("b_ack_addr", nack, 0);
    read_byte(1'b0, rd); check("b_rd0", rd, 8'h11);
    read_byte(1'b0, rd); check("b_rd1", rd, 8'h22);
    read_byte(1'b1, rd); check("b_rd2", rd, 8'h33);
    i2c_stop();
    check("b_re_count", re_cnt - re0, 3);
    check("b_ptr_end", reg_addr, 5);

    // Foreign address: no ACK, no drive, no writes
    we0 = we_cnt; oe0 = oe_cyc; ad0 = adr_cyc;
    i2c_start();
    write_byte(8'hA0, nack); check("c_nack_addr", nack, 1);
    write_byte(8'h01, nack); check("c_nack_d0", nack, 1);
    write_byte(8'h77, nack);
    i2c_stop();
    check("c_oe_cycles", oe_cyc - oe0, 0);
    check("c_addr_cycles", adr_cyc - ad0, 0);
    check("c_we_count", we_cnt - we0, 0);
    check("c_ptr", reg_addr, 5);

    // Pointer wrap, then out-of-range pointer
    we0 = we_cnt;
    i2c_start();
    write_byte(8'hD4, nack);
    write_byte(8'h0F, nack); check("d_ack_ptr", nack, 0);
    write_byte(8'hC3, nack);
    write_byte(8'h3C, nack);
    i2c_stop();
    check("d_we0_addr", we_addr_log[we0[5:0]], 15);
    check("d_we0_data", we_data_log[we0[5:0]], 8'hC3);
    check("d_we1_addr", we_addr_log[we0[5:0] + 6'd1], 0);
    check("d_we1_data", we_data_log[we0[5:0] + 6'd1], 8'h3C);
    check("d_ptr_wrap", reg_addr, 1);
    i2c_start();
    write_byte(8'hD4, nack);
    write_byte(8'h10, nack); check("d_nack_ptr", nack, 1);
    check("d_ack_error", ack_error, 1);
    check("d_ptr_keep", reg_addr, 1);
    i2c_stop();
    check("d_ack_error_sticky", ack_error, 1);
    i2c_start();
    check("d_ack_error_clr", ack_error, 0);
    i2c_stop();

    // Reset while driving read bit 4 of 0x22 (a 0, so SDA pulled low)
    i2c_start();
    write_byte(8'hD4, nack);
    write_byte(8'h03, nack);
    i2c_start();
    write_byte(8'hD5, nack);
    bit_io(1'b1, s); check("e_bit7", s, 0);
    bit_io(1'b1, s); check("e_bit6", s, 0);
    bit_io(1'b1, s); check("e_bit5", s, 1);
    check("e_drive_pre", sda_oe, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("e_rst");
    tick(3);
    reset = 1'b0;
    tick(4);
    i2c_stop();
    i2c_start();
    write_byte(8'hD4, nack); check("e_ack_addw", nack, 0);
    write_byte(8'h04, nack); check("e_ack_ptr", nack, 0);
    i2c_start();
    write_byte(8'hD5, nack); check("e_ack_addr", nack, 0);
    read_byte(1'b1, rd); check("e_rd", rd, 8'h33);
    i2c_stop();
    check("e_ptr_end", reg_addr, 5);

`ifdef I2C_SLAVE_FILTER_EN
    // Glitch rejection with SCL held high
    tick(10);
    sda_m = 1'b0; tick(2); sda_m = 1'b1;
    tick(12);
    check("f_glitch_busy", busy, 0);
    sda_m = 1'b0; tick(5); sda_m = 1'b1;
    tick(3);
    check("f_start_busy", busy, 1);
    tick(15);
    check("f_stop_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
